// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage_if
// Data-memory port between the load/store stage and the data memory.
//   req    LSU -> mem  request, held until ack
//   we     LSU -> mem  1 = write
//   addr   LSU -> mem  word address (low two bits always 0)
//   wdata  LSU -> mem  store data replicated/shifted onto its byte lanes
//   be     LSU -> mem  byte enables
//   ack    mem -> LSU  access completes this cycle
//   rdata  mem -> LSU  read word, valid with ack
// Modports: master = LSU side, slave = memory side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface lsu_mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Memory-access stage of the single-core RV32I datapath. Takes the ALU result
// as effective address for LB/LH/LW/LBU/LHU/SB/SH/SW, runs one req/ack access
// on the data-memory port and returns extended load data with a one-cycle
// done pulse. The core stalls while busy is high.
//
// Parameter:
//   TIMEOUT   ack-wait cycles before the access is aborted with bus_err
//             (0 = wait forever)
// Optional feature macro:
//   MISALIGN_TRAP_EN  when defined, a misaligned half/word access never reaches
//                     the bus and completes with misaligned=1; when undefined
//                     the low address bits only select byte lanes.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid/req_ready  request from core; ready only in IDLE
//   mem_read, mem_write  load / store (both set = load)
//   funct3               RV32I size/sign encoding
//   alu_result           effective address
//   store_data           rs2 value
//   dmem                 data-memory port (master modport)
//   load_data            extended load result, held until the next done
//   done                 one-cycle completion pulse
//   misaligned, bus_err  status, valid only with done
//   busy                 stall to core (state != IDLE)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     store_data,
    lsu_mem_stage_if.master dmem,
    output logic [31:0]     load_data,
    output logic            done,
    output logic            misaligned,
    output logic            bus_err,
    output logic            busy
);

    // Counter only ever needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic           req_reg, req_next;
    logic           we_reg, we_next;
    logic [31:0]    addr_reg, addr_next;
    logic [31:0]    wdata_reg, wdata_next;
    logic [3:0]     be_reg, be_next;
    logic [1:0]     lane_reg, lane_next;
    logic [2:0]     f3_reg, f3_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [31:0]    load_data_reg, load_data_next;
    logic           done_reg, done_next;
    logic           mis_reg, mis_next;
    logic           err_reg, err_next;

    // ---------------- request decode (from core inputs) ----------------
    logic [1:0]  a;
    logic        is_access;
    logic        req_mis;
    logic [3:0]  be_b;
    logic [31:0] wdata_b;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte [4];

    assign a         = alu_result[1:0];
    assign is_access = mem_read | mem_write;

    // Per-lane byte enable / byte replication / read-byte split.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be_b[gi]             = (a == 2'(gi));
            assign wdata_b[8*gi +: 8]   = store_data[7:0];
            assign rd_byte[gi]          = dmem.rdata[8*gi +: 8];
        end
    endgenerate

    // funct3[2] only affects load extension, so stores ignore it here.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                req_be    = be_b;
                req_wdata = wdata_b;
            end
            2'b01: begin
                req_be    = 4'b0011 << {a[1], 1'b0};
                req_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign req_mis = is_access &&
                     (((funct3[1:0] == 2'b01) && a[0]) || (funct3[1] && (a != 2'b00)));
`else
    assign req_mis = 1'b0;
`endif

    // ---------------- load extraction (from captured lane/size) ----------------
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    assign ld_b = rd_byte[lane_reg];
    assign ld_h = lane_reg[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    always_comb begin
        ld_ext = dmem.rdata;
        case (f3_reg[1:0])
            2'b00:   ld_ext = f3_reg[2] ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'b01:   ld_ext = f3_reg[2] ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_ext = dmem.rdata;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_reg) == TIMEOUT - 1);

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        be_next        = be_reg;
        lane_next      = lane_reg;
        f3_next        = f3_reg;
        cnt_next       = cnt_reg;
        load_data_next = load_data_reg;
        done_next      = 1'b0;
        mis_next       = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    f3_next = funct3;
                    if (!is_access || req_mis) begin
                        // Nothing goes on the bus; complete in the next cycle.
                        state_next     = RESP;
                        done_next      = 1'b1;
                        mis_next       = req_mis;
                        load_data_next = 32'b0;
                    end else begin
                        state_next = REQ;
                        req_next   = 1'b1;
                        we_next    = mem_write & ~mem_read;
                        addr_next  = {alu_result[31:2], 2'b00};
                        wdata_next = req_wdata;
                        be_next    = req_be;
                        lane_next  = a;
                        cnt_next   = '0;
                    end
                end
            end
            REQ: begin
                // Ack has priority over an expiring timeout.
                if (dmem.ack) begin
                    state_next     = RESP;
                    req_next       = 1'b0;
                    done_next      = 1'b1;
                    load_data_next = we_reg ? 32'b0 : ld_ext;
                end else if (timeout_hit) begin
                    state_next     = RESP;
                    req_next       = 1'b0;
                    done_next      = 1'b1;
                    err_next       = 1'b1;
                    load_data_next = 32'b0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'b0;
            wdata_reg     <= 32'b0;
            be_reg        <= 4'b0;
            lane_reg      <= 2'b0;
            f3_reg        <= 3'b0;
            cnt_reg       <= '0;
            load_data_reg <= 32'b0;
            done_reg      <= 1'b0;
            mis_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            be_reg        <= be_next;
            lane_reg      <= lane_next;
            f3_reg        <= f3_next;
            cnt_reg       <= cnt_next;
            load_data_reg <= load_data_next;
            done_reg      <= done_next;
            mis_reg       <= mis_next;
            err_reg       <= err_next;
        end
    end

    assign dmem.req   = req_reg;
    assign dmem.we    = we_reg;
    assign dmem.addr  = addr_reg;
    assign dmem.wdata = wdata_reg;
    assign dmem.be    = be_reg;

    assign load_data  = load_data_reg;
    assign done       = done_reg;
    assign misaligned = mis_reg;
    assign bus_err    = err_reg;
    assign busy       = (state_reg != IDLE);
    assign req_ready  = (state_reg == IDLE);

endmodule
